// File: rtl/lstm_credit_fifo_pkg.sv
// Shared constants for the LSTM credit FIFO slice.
//   FIFO_XLEN      : default data word width, taken from the LSTM word length
//   FIFO_DEPTH_DEF : default number of buffer entries
`ifndef LSTM_XLEN
`define LSTM_XLEN 16
`endif

package lstm_credit_fifo_pkg;
  localparam int unsigned FIFO_XLEN      = `LSTM_XLEN;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
endpackage

// File: rtl/lstm_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the controlling FIFO.
//   clock   : rising-edge clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module lstm_fifo_mem
  import lstm_credit_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_XLEN,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lstm_credit_fifo.sv
// Receive-side elastic buffer behind a non-stallable fixed-latency delay line.
// Upstream holds a credit for every token it issues until the matching word is
// read out, so words leaving the delay line always find space.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   issue          : upstream pushed a token into the delay line this cycle
//   in_valid/data_in : delay-line output word (no backpressure)
//   out_valid/out_ready/data_out : first-word fall-through consumer port
//   stall_upstream : no credit left
//   count          : words currently stored
//   overflow_err   : sticky, a write was dropped because the buffer was full
//   credit_err     : sticky, issue arrived while stall_upstream was high
module lstm_credit_fifo
  import lstm_credit_fifo_pkg::*;
#(
  parameter int unsigned INPUT_BITS_NUM = FIFO_XLEN,
  parameter int unsigned DEPTH          = FIFO_DEPTH_DEF,
  localparam int unsigned CNT_BITS      = $clog2(DEPTH) + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue,
  input  logic                      in_valid,
  input  logic [INPUT_BITS_NUM-1:0] data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INPUT_BITS_NUM-1:0] data_out,
  output logic                      stall_upstream,
  output logic [CNT_BITS-1:0]       count,
  output logic                      overflow_err,
  output logic                      credit_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);

  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]       count_q, count_d;
  logic [CNT_BITS-1:0]       reserved_q, reserved_d;
  logic                      ovf_q, ovf_d;
  logic                      cerr_q, cerr_d;
  logic                      rd_fire, wr_fire, issue_ok;
  logic [INPUT_BITS_NUM-1:0] mem_rdata;

  assign out_valid      = (count_q != '0);
  assign stall_upstream = (reserved_q == DEPTH_C);
  assign data_out       = out_valid ? mem_rdata : '0;
  assign count          = count_q;
  assign overflow_err   = ovf_q;
  assign credit_err     = cerr_q;

  always_comb begin
    rd_fire    = out_valid & out_ready;
    // A full buffer still takes a write when the head leaves in the same cycle.
    wr_fire    = in_valid & ((count_q < DEPTH_C) | rd_fire);
    issue_ok   = issue & ~stall_upstream;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_BITS'(wr_fire) - CNT_BITS'(rd_fire);
    reserved_d = reserved_q + CNT_BITS'(issue_ok);
    // Words that arrive without a credit must not drive the reservation negative.
    if (rd_fire && (reserved_d != '0)) reserved_d = reserved_d - 1'b1;
    ovf_d      = ovf_q | (in_valid & ~wr_fire);
    cerr_d     = cerr_q | (issue & stall_upstream);
    // Power-of-two depth: pointer wrap is the natural modulo of PTR_W bits.
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      reserved_q <= '0;
      ovf_q      <= 1'b0;
      cerr_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      reserved_q <= reserved_d;
      ovf_q      <= ovf_d;
      cerr_q     <= cerr_d;
    end
  end

  lstm_fifo_mem #(
    .WIDTH (INPUT_BITS_NUM),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_lstm_credit_fifo.sv
// Directed bench for lstm_credit_fifo (DEPTH 8, 16-bit words).
module tb_lstm_credit_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] data_out;
  logic        stall_upstream;
  logic [3:0]  count;
  logic        overflow_err;
  logic        credit_err;

  int tests = 0;
  int fails = 0;

  lstm_credit_fifo #(
    .INPUT_BITS_NUM (16),
    .DEPTH          (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .issue          (issue),
    .in_valid       (in_valid),
    .data_in        (data_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_out       (data_out),
    .stall_upstream (stall_upstream),
    .count          (count),
    .overflow_err   (overflow_err),
    .credit_err     (credit_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int issued;
    int first_stall;
    logic [15:0] exp_q [8];

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_stall", stall_upstream, 0);
    check("rst_data_out", data_out, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_cerr", credit_err, 0);
    reset = 1'b0;

    // Test 1: single token, word arrives four cycles after issue
    issue = 1'b1;
    tick();
    issue = 1'b0;
    tick(); tick(); tick();
    in_valid = 1'b1; data_in = 16'h0001;
    check("t1_no_bypass", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", out_valid, 1);
    check("t1_data", data_out, 16'h0001);
    check("t1_count1", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_count0", count, 0);
    check("t1_stall", stall_upstream, 0);
    check("t1_empty_data", data_out, 0);

    // Test 2: upstream issues while it has credit; delay line of 4
    issued = 0;
    first_stall = -1;
    for (int i = 0; i < 12; i++) begin
      if (stall_upstream && first_stall < 0) first_stall = i;
      issue    = ~stall_upstream;
      if (!stall_upstream) issued++;
      in_valid = (i >= 4);
      data_in  = 16'(i - 3);
      tick();
    end
    issue = 1'b0; in_valid = 1'b0;
    check("t2_issued", issued, 8);
    check("t2_first_stall", first_stall, 8);
    check("t2_count", count, 8);
    check("t2_stall", stall_upstream, 1);
    check("t2_ovf", overflow_err, 0);
    check("t2_head", data_out, 16'h0001);

    // Test 3: full, write and read together
    in_valid = 1'b1; data_in = 16'h00AA; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t3_count", count, 8);
    check("t3_head", data_out, 16'h0002);
    check("t3_ovf", overflow_err, 0);
    check("t3_stall_open", stall_upstream, 0);
    // Take the freed credit back so reservation is full again
    issue = 1'b1;
    tick();
    issue = 1'b0;
    check("t3_stall_full", stall_upstream, 1);
    check("t3_cerr", credit_err, 0);

    // Test 4: full, write without read is dropped
    in_valid = 1'b1; data_in = 16'h0055;
    tick();
    in_valid = 1'b0;
    check("t4_ovf", overflow_err, 1);
    check("t4_count", count, 8);
    check("t4_head", data_out, 16'h0002);

    // Test 5: issue while stalled
    issue = 1'b1;
    tick();
    issue = 1'b0;
    check("t5_cerr", credit_err, 1);
    check("t5_stall", stall_upstream, 1);

    // Drain: 2..8 then AA; one read re-opens credit (reservation was 8, not more)
    exp_q = '{16'h0002, 16'h0003, 16'h0004, 16'h0005,
              16'h0006, 16'h0007, 16'h0008, 16'h00AA};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_%0d", k), data_out, exp_q[k]);
      out_ready = 1'b1;
      tick();
      if (k == 0) check("t5_stall_reopen", stall_upstream, 0);
    end
    out_ready = 1'b0;
    check("drain_count", count, 0);
    check("drain_out_valid", out_valid, 0);
    check("drain_ovf_sticky", overflow_err, 1);

    // Test 6: fill 5, reset mid-operation
    for (int k = 0; k < 5; k++) begin
      issue = 1'b1; in_valid = 1'b1; data_in = 16'(16'h0010 + k);
      tick();
    end
    issue = 1'b0; in_valid = 1'b0;
    check("t6_fill_count", count, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_count", count, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_stall", stall_upstream, 0);
    check("t6_ovf", overflow_err, 0);
    check("t6_cerr", credit_err, 0);

    // 12 overlapping write/read pairs across the pointer wrap
    for (int j = 0; j < 12; j++) begin
      if (j > 0) check($sformatf("wrap_%0d", j), data_out, 16'(16'h0100 + j - 1));
      issue = 1'b1; in_valid = 1'b1; data_in = 16'(16'h0100 + j); out_ready = 1'b1;
      tick();
    end
    issue = 1'b0; in_valid = 1'b0;
    check("wrap_count", count, 1);
    check("wrap_last", data_out, 16'h010B);
    tick();
    out_ready = 1'b0;
    check("wrap_empty", count, 0);
    check("wrap_ovf", overflow_err, 0);
    check("wrap_cerr", credit_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
